router_read_arbiter: RTL
========================

Name: router_read_arbiter

Overview:
- Output-side packet scheduler for the 1x3 router.
- Drains the three router output FIFOs (valid_out_N / read_enb_N / data_out_N) onto a single shared downstream byte stream.
- Grants whole packets round-robin, so packets never interleave on the shared port.
- Absorbs the FIFO's 1-cycle read latency and downstream backpressure with a 2-entry skid buffer.

Parameters:
- DATA_WIDTH, 8, byte width of FIFO data and downstream data.
- LEN_W, 6, payload-length field width, taken from header bits [7:2].

Ports:
- clock  in  1  single clock; all logic on posedge.
- resetn  in  1  asynchronous, active-low reset.
- valid_out_0/1/2  in  1 each  router FIFO N non-empty.
- data_out_0/1/2  in  8 each  router FIFO N read data, valid 1 cycle after read_enb_N.
- read_enb_0/1/2  out  1 each  read strobe to FIFO N.
- m_data  out  8  downstream byte.
- m_valid  out  1  downstream byte valid.
- m_sop  out  1  marks header byte.
- m_eop  out  1  marks parity byte.
- m_port  out  2  source port of the current byte (0..2).
- m_ready  in  1  downstream accept; a transfer occurs when m_valid && m_ready.
- busy  out  1  high from grant to last byte accepted.
- pkt_err  out  1  parity-error pulse (optional feature only).

Behaviour:
- Reset values: all read_enb_N=0, m_valid=0, m_data=0, m_sop=0, m_eop=0, m_port=0, busy=0, pkt_err=0. Round-robin pointer resets to port 0 as highest priority. Skid buffer empty, counters 0, FSM in IDLE. Reset mid-packet discards all state immediately.
- Packet format: header byte with addr in [1:0] and len in [7:2]; then len payload bytes; then 1 parity byte. Total bytes = len+2, so len=0 gives 2 bytes.
- State IDLE:
  - Evaluate valid_out_N round-robin, starting from the port after the last granted one.
  - On any request, latch the winner in gnt, set busy=1, go to HDR. Else stay.
- State HDR: issue one read to gnt (subject to the read rule). Next cycle capture the header, load remaining=len+1, go to BODY.
- State BODY: issue reads while remaining>0 and the read rule holds. Decrement remaining per read issued. When the final read is issued, go to DRAIN.
- State DRAIN: wait until the skid buffer is empty, i.e. the parity byte has been accepted. Then:
  - busy=0;
  - advance the round-robin pointer to gnt+1 (mod 3);
  - go to IDLE.
  - Earliest next grant is the cycle after.
- Read rule:
  - read_enb_gnt = valid_out_gnt && (skid_count + inflight) < 2.
  - inflight = read issued last cycle.
  - read_enb to non-granted ports is always 0.
  - At most one read_enb_N high per cycle.
- Data path: the returned byte is written to the skid buffer (FIFO order). m_data/m_valid/m_sop/m_eop/m_port are presented from the buffer head, which pops on m_valid && m_ready.
- Markers: m_sop=1 on the header byte only; m_eop=1 on byte index len+1 only.
- Latency: with m_ready=1 and data available, the header appears on m_data 2 cycles after grant. Sustained throughput is 1 byte/cycle.
- Boundaries:
  - valid_out_gnt drops mid-packet (writer slower than reader): reads stall, state held, no timeout. Resume when valid_out returns.
  - m_ready low: at most 2 bytes buffered. No overflow, no byte lost or duplicated.
  - Simultaneous requests in IDLE: pointer order decides.
  - A newly arriving request on another port never preempts a granted packet.
  - Header read with len=0: BODY issues exactly one read (the parity byte).

Optional Feature:
- Macro: ROUTER_ARB_PARITY_CHECK_EN.
- With the macro defined:
  - XOR header and payload bytes as they pop from the skid buffer;
  - compare against the parity byte;
  - pkt_err=1 for exactly the cycle the eop byte is accepted, if they mismatch.
  - Data is forwarded unchanged.
- Without the macro: no parity logic; pkt_err tied to 0.

Test Plan:
- Port 1 packet, header 0x0D (len 3, addr 1), payload 0x11,0x22,0x33, parity 0x0D^0x11^0x22^0x33, m_ready=1 -> exactly 5 bytes on m_data, m_sop on byte 0, m_eop on byte 4, m_port=1, read_enb_1 pulsed 5 times, busy falls after the eop transfer.
- valid_out_0/1/2 all high at reset release, each with a len-2 packet -> grant order 0,1,2. Then re-request port 0 and port 2 -> port 0 granted next.
- m_ready toggled 1,0,0,1,… during a len-10 packet -> all 12 bytes in order, never more than 2 reads outstanding, none lost or duplicated.
- valid_out_2 deasserted for 5 cycles after byte 2 of a len-6 packet -> read_enb_2 stays low for those 5 cycles, then the packet completes correctly.
- resetn pulsed low mid-BODY -> all outputs return to reset values the same cycle. The next packet is granted from port 0 priority and framed correctly.
- With ROUTER_ARB_PARITY_CHECK_EN, parity byte corrupted to 0xFF on a len-1 packet -> pkt_err=1 for exactly one cycle, coincident with the m_eop transfer. Without the macro, pkt_err stays 0.

Source files
------------

// File: rtl/router_read_arbiter.sv
// Output-side packet scheduler: drains three router FIFOs onto one byte stream, whole packets round-robin.
// Optional parity check of the trailing byte is built when ROUTER_ARB_PARITY_CHECK_EN is defined.
module router_read_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_W      = 6
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  valid_out_0,
  input  logic                  valid_out_1,
  input  logic                  valid_out_2,
  input  logic [DATA_WIDTH-1:0] data_out_0,
  input  logic [DATA_WIDTH-1:0] data_out_1,
  input  logic [DATA_WIDTH-1:0] data_out_2,
  output logic                  read_enb_0,
  output logic                  read_enb_1,
  output logic                  read_enb_2,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  output logic                  m_sop,
  output logic                  m_eop,
  output logic [1:0]            m_port,
  input  logic                  m_ready,
  output logic                  busy,
  output logic                  pkt_err
);

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_BODY, S_DRAIN} state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  sop;
    logic                  eop;
    logic [1:0]            port;
  } entry_t;

  localparam logic [LEN_W:0] REM_ONE = (LEN_W+1)'(1);

  function automatic logic [1:0] next_port(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  state_t          r_state;
  logic [1:0]      r_gnt;
  logic [1:0]      r_ptr;
  logic            r_busy;
  logic [LEN_W:0]  r_remaining;
  logic            r_inflight;
  logic            r_inflight_last;
  entry_t          r_mem [2];
  logic            r_wr_ptr;
  logic            r_rd_ptr;
  logic [1:0]      r_count;

  logic [2:0]            w_valid;
  logic                  w_gnt_valid;
  logic [DATA_WIDTH-1:0] w_rd_data;
  logic [1:0]            w_p0, w_p1, w_p2;
  logic [1:0]            w_winner;
  logic                  w_req_any;
  logic                  w_pop;
  logic [2:0]            w_occ;
  logic                  w_room;
  logic                  w_rd;
  logic                  w_hdr_arrive;
  entry_t                w_head;
  entry_t                w_wr_entry;

  assign w_valid = {valid_out_2, valid_out_1, valid_out_0};

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    w_gnt_valid = 1'b0;
    w_rd_data   = '0;
    case (r_gnt)
      2'd0:    begin w_gnt_valid = valid_out_0; w_rd_data = data_out_0; end
      2'd1:    begin w_gnt_valid = valid_out_1; w_rd_data = data_out_1; end
      2'd2:    begin w_gnt_valid = valid_out_2; w_rd_data = data_out_2; end
      default: begin w_gnt_valid = 1'b0;        w_rd_data = '0;         end
    endcase
  end

  // Search order starts at r_ptr, the port after the last one served.
  assign w_p0 = r_ptr;
  assign w_p1 = next_port(w_p0);
  assign w_p2 = next_port(w_p1);

  always_comb begin
    w_req_any = |w_valid;
    w_winner  = w_p2;
    if (w_valid[w_p0])      w_winner = w_p0;
    else if (w_valid[w_p1]) w_winner = w_p1;
  end

  // A slot freed by this cycle's pop is reusable, which keeps one byte per cycle flowing.
  assign w_pop        = (r_count != 2'd0) && m_ready;
  assign w_occ        = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_room       = (w_occ < 3'd2);
  assign w_rd         = (((r_state == S_HDR) && !r_inflight) ||
                         ((r_state == S_BODY) && (r_remaining != '0))) && w_gnt_valid && w_room;
  assign w_hdr_arrive = (r_state == S_HDR) && r_inflight;

  assign read_enb_0 = w_rd && (r_gnt == 2'd0);
  assign read_enb_1 = w_rd && (r_gnt == 2'd1);
  assign read_enb_2 = w_rd && (r_gnt == 2'd2);

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state         <= S_IDLE;
      r_gnt           <= 2'd0;
      r_ptr           <= 2'd0;
      r_busy          <= 1'b0;
      r_remaining     <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
    end else begin
      r_inflight      <= w_rd;
      r_inflight_last <= w_rd && (r_state == S_BODY) && (r_remaining == REM_ONE);
      case (r_state)
        S_IDLE: if (w_req_any) begin
          r_gnt   <= w_winner;
          r_busy  <= 1'b1;
          r_state <= S_HDR;
        end
        S_HDR: if (r_inflight) begin
          r_remaining <= {1'b0, w_rd_data[2 +: LEN_W]} + REM_ONE;
          r_state     <= S_BODY;
        end
        S_BODY: if (w_rd) begin
          r_remaining <= r_remaining - REM_ONE;
          if (r_remaining == REM_ONE) r_state <= S_DRAIN;
        end
        S_DRAIN: if (!r_inflight && ((r_count == 2'd0) || ((r_count == 2'd1) && w_pop))) begin
          r_busy  <= 1'b0;
          r_ptr   <= next_port(r_gnt);
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign w_wr_entry = '{data: w_rd_data, sop: w_hdr_arrive, eop: r_inflight_last, port: r_gnt};

  // NOTE: the two buffer entries are reset because the head drives the outputs directly.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (r_inflight) begin
        r_mem[r_wr_ptr] <= w_wr_entry;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + {1'b0, r_inflight} - {1'b0, w_pop};
    end
  end

  assign w_head  = r_mem[r_rd_ptr];
  assign m_valid = (r_count != 2'd0);
  assign m_data  = w_head.data;
  assign m_sop   = w_head.sop;
  assign m_eop   = w_head.eop;
  assign m_port  = w_head.port;
  assign busy    = r_busy;

`ifdef ROUTER_ARB_PARITY_CHECK_EN
  logic [DATA_WIDTH-1:0] r_par;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_par <= '0;
    end else if (w_pop) begin
      if (w_head.sop)      r_par <= w_head.data;
      else if (w_head.eop) r_par <= '0;
      else                 r_par <= r_par ^ w_head.data;
    end
  end

  assign pkt_err = w_pop && w_head.eop && (r_par != w_head.data);
`else
  assign pkt_err = 1'b0;
`endif

endmodule
